i2c_bus_det: RTL and testbench



---
 rtl/i2c_bus_det.sv | 148 ++++++++++++++
 tb/tb_i2c_bus_det.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/i2c_bus_det.sv
// Purpose: I2C pad-line conditioner. Synchronises and de-glitches SCL/SDA, and
//          produces SCL edge strobes, START/STOP pulses, bus-busy and an SCL-low timeout.
// Latency: pad -> scl_f/sda_f is 2 sync + (filt_len+1) filter cycles (fixed 3 without filter).
// Backpressure: none. Strobes are single-cycle and unqualified, so consumers must sample every cycle.
//
// Ports: clk/rstn (async active-low); scl_i/sda_i raw pads; filt_len glitch length-1;
//        tout_val SCL-low timeout (0 = off); scl_f/sda_f filtered levels; scl_rise/scl_fall,
//        sta_det/sto_det, tout one-cycle strobes; bus_busy level.
// Build option: define I2C_BUS_DET_FILT_EN to include the glitch filter counters.
module i2c_bus_det #(
    parameter int FILT_W = 4,
    parameter int TOUT_W = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              scl_i,
    input  logic              sda_i,
    input  logic [FILT_W-1:0] filt_len,
    input  logic [TOUT_W-1:0] tout_val,
    output logic              scl_f,
    output logic              sda_f,
    output logic              scl_rise,
    output logic              scl_fall,
    output logic              sta_det,
    output logic              sto_det,
    output logic              bus_busy,
    output logic              tout
);

    logic [1:0]        scl_sync;
    logic [1:0]        sda_sync;
    logic              scl_s;
    logic              sda_s;
    logic              scl_d;
    logic              sda_d;
    logic [TOUT_W-1:0] tcnt;
    logic [TOUT_W-1:0] tcnt_nxt;
    logic              tout_nxt;

    assign scl_s = scl_sync[1];
    assign sda_s = sda_sync[1];

    // Two-flop synchronisers reset to the idle-high bus level.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
        end else begin
            scl_sync <= {scl_sync[0], scl_i};
            sda_sync <= {sda_sync[0], sda_i};
        end
    end

`ifdef I2C_BUS_DET_FILT_EN
    logic [FILT_W-1:0] scl_cnt;
    logic [FILT_W-1:0] sda_cnt;

    // A new level is accepted only after it has differed from the filtered
    // value for filt_len+1 consecutive cycles; any agreement restarts the count.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            scl_f   <= 1'b1;
            sda_f   <= 1'b1;
            scl_cnt <= '0;
            sda_cnt <= '0;
        end else begin
            if (scl_s == scl_f) begin
                scl_cnt <= '0;
            end else if (scl_cnt == filt_len) begin
                scl_f   <= scl_s;
                scl_cnt <= '0;
            end else begin
                scl_cnt <= scl_cnt + 1'b1;
            end

            if (sda_s == sda_f) begin
                sda_cnt <= '0;
            end else if (sda_cnt == filt_len) begin
                sda_f   <= sda_s;
                sda_cnt <= '0;
            end else begin
                sda_cnt <= sda_cnt + 1'b1;
            end
        end
    end
`else
    // Filter absent: filt_len is kept on the port for drop-in compatibility.
    logic unused_filt_len;
    assign unused_filt_len = ^filt_len;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            scl_f <= 1'b1;
            sda_f <= 1'b1;
        end else begin
            scl_f <= scl_s;
            sda_f <= sda_s;
        end
    end
`endif

    // Previous-cycle filtered levels for edge and START/STOP detection.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            scl_d <= 1'b1;
            sda_d <= 1'b1;
        end else begin
            scl_d <= scl_f;
            sda_d <= sda_f;
        end
    end

    assign scl_rise = scl_f & ~scl_d;
    assign scl_fall = ~scl_f & scl_d;
    // SCL must be high in both cycles, so a simultaneous SCL/SDA change is ignored.
    assign sta_det  = scl_f & scl_d & ~sda_f & sda_d;
    assign sto_det  = scl_f & scl_d & sda_f & ~sda_d;

    // Timeout counter: runs only while busy with SCL low; saturates so tout
    // fires once per low period and re-arms only after the counter clears.
    always_comb begin
        tcnt_nxt = tcnt;
        if ((tout_val == '0) || scl_f || !bus_busy) begin
            tcnt_nxt = '0;
        end else if (tcnt != tout_val) begin
            tcnt_nxt = tcnt + 1'b1;
        end
    end

    assign tout_nxt = (tout_val != '0) && (tcnt_nxt == tout_val) && (tcnt != tout_val);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tcnt     <= '0;
            tout     <= 1'b0;
            bus_busy <= 1'b0;
        end else begin
            tcnt <= tcnt_nxt;
            tout <= tout_nxt;
            if (sta_det) begin
                bus_busy <= 1'b1;
            end else if (sto_det || tout) begin
                bus_busy <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i2c_bus_det.sv
module tb_i2c_bus_det;

    logic        clk;
    logic        rstn;
    logic        scl_i;
    logic        sda_i;
    logic [3:0]  filt_len;
    logic [15:0] tout_val;
    logic        scl_f;
    logic        sda_f;
    logic        scl_rise;
    logic        scl_fall;
    logic        sta_det;
    logic        sto_det;
    logic        bus_busy;
    logic        tout;

    int n_chk;
    int n_fail;
    int lat;

    i2c_bus_det #(.FILT_W(4), .TOUT_W(16)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .scl_i    (scl_i),
        .sda_i    (sda_i),
        .filt_len (filt_len),
        .tout_val (tout_val),
        .scl_f    (scl_f),
        .sda_f    (sda_f),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .sta_det  (sta_det),
        .sto_det  (sto_det),
        .bus_busy (bus_busy),
        .tout     (tout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_chk    = 0;
        n_fail   = 0;
        rstn     = 1'b0;
        scl_i    = 1'b1;
        sda_i    = 1'b1;
        filt_len = 4'd3;
        tout_val = 16'd0;
`ifdef I2C_BUS_DET_FILT_EN
        lat = 6;
`else
        lat = 3;
`endif

        // Reset values
        repeat (3) tick();
        chk("rst_scl_f", scl_f, 1);
        chk("rst_sda_f", sda_f, 1);
        chk("rst_strobes", {scl_rise, scl_fall, sta_det, sto_det, tout}, 0);
        chk("rst_busy", bus_busy, 0);

        // Idle after release
        rstn = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk("idle", {scl_rise, scl_fall, sta_det, sto_det, tout, bus_busy, scl_f, sda_f}, 8'b0000_0011);
        end

        // START
        sda_i = 1'b0;
        for (int k = 1; k <= lat; k++) begin
            tick();
            chk("start_sta", sta_det, k == lat);
            chk("start_busy_pre", bus_busy, 0);
        end
        tick();
        chk("start_busy", bus_busy, 1);
        chk("start_sta_end", sta_det, 0);

        // STOP
        sda_i = 1'b1;
        for (int k = 1; k <= lat; k++) begin
            tick();
            chk("stop_sto", sto_det, k == lat);
            chk("stop_busy_pre", bus_busy, 1);
        end
        tick();
        chk("stop_busy", bus_busy, 0);

`ifdef I2C_BUS_DET_FILT_EN
        // 3-cycle glitch is rejected
        scl_i = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            tick();
            if (k == 3) scl_i = 1'b1;
            chk("glitch_fall", scl_fall, 0);
            chk("glitch_scl_f", scl_f, 1);
        end
        // 4-cycle pulse passes
        scl_i = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            tick();
            if (k == 4) scl_i = 1'b1;
            chk("pulse4_fall", scl_fall, k == 6);
            chk("pulse4_rise", scl_rise, k == 10);
        end
`else
        // Filter absent: 1-cycle pulse passes with fixed latency
        filt_len = 4'd15;
        scl_i = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 1) scl_i = 1'b1;
            chk("byp_fall", scl_fall, k == 3);
            chk("byp_rise", scl_rise, k == 4);
            chk("byp_scl_f", scl_f, k != 3);
        end
        filt_len = 4'd3;
`endif

        // Simultaneous SCL/SDA change: no START/STOP
        scl_i = 1'b0;
        sda_i = 1'b0;
        for (int k = 1; k <= lat + 2; k++) begin
            tick();
            chk("sim_fall", scl_fall, k == lat);
            chk("sim_sta_sto", {sta_det, sto_det}, 0);
        end
        scl_i = 1'b1;
        sda_i = 1'b1;
        for (int k = 1; k <= lat + 2; k++) begin
            tick();
            chk("sim_rise", scl_rise, k == lat);
            chk("sim_sta_sto2", {sta_det, sto_det, bus_busy}, 0);
        end

        // Timeout with tout_val = 100
        tout_val = 16'd100;
        sda_i = 1'b0;
        repeat (lat + 1) tick();
        chk("to_busy_set", bus_busy, 1);
        scl_i = 1'b0;
        repeat (lat) tick();
        chk("to_scl_fall", scl_fall, 1);
        for (int k = 1; k <= 130; k++) begin
            tick();
            chk("to_pulse", tout, k == 100);
            chk("to_busy", bus_busy, k <= 100);
        end
        scl_i = 1'b1;
        repeat (lat + 1) tick();
        sda_i = 1'b1;
        repeat (lat + 1) tick();
        chk("to_idle_busy", bus_busy, 0);

        // Timeout disabled
        tout_val = 16'd0;
        sda_i = 1'b0;
        repeat (lat + 1) tick();
        scl_i = 1'b0;
        for (int k = 1; k <= 150; k++) begin
            tick();
            chk("to0_pulse", tout, 0);
            chk("to0_busy", bus_busy, 1);
        end

        // Reset mid-transfer takes effect immediately
        rstn = 1'b0;
        #1;
        chk("mid_rst_lines", {scl_f, sda_f}, 2'b11);
        chk("mid_rst_busy", bus_busy, 0);
        chk("mid_rst_strobes", {scl_rise, scl_fall, sta_det, sto_det, tout}, 0);
        scl_i = 1'b1;
        sda_i = 1'b1;
        repeat (2) tick();
        rstn = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk("post_rst_idle", {scl_rise, scl_fall, sta_det, sto_det, tout, bus_busy, scl_f, sda_f}, 8'b0000_0011);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
